// File: rtl/tile_scheduler.sv
// tile_scheduler: walks an M x N x K tiled matrix-multiply job, issuing one
// start per tile product to the single-tile systolic controller, waiting for
// its done, and presenting tile indices plus accumulation flags to the
// A/B/C buffer address logic. Loop order is K innermost, then N, then M.
module tile_scheduler #(
  parameter int TILE  = 8,
  parameter int DIM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIM_W-1:0] cfg_m_tiles,
  input  logic [DIM_W-1:0] cfg_n_tiles,
  input  logic [DIM_W-1:0] cfg_k_tiles,
  input  logic             abort,
  input  logic             ctrl_ready,
  output logic             ctrl_start,
  input  logic             ctrl_done,
  output logic [DIM_W-1:0] tile_m,
  output logic [DIM_W-1:0] tile_n,
  output logic [DIM_W-1:0] tile_k,
  output logic             acc_clear,
  output logic             acc_last,
  output logic             busy,
  output logic             job_done,
  output logic             cfg_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    NEXT   = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam logic [DIM_W-1:0] ZERO = {DIM_W{1'b0}};
  localparam logic [DIM_W-1:0] ONE  = {{(DIM_W-1){1'b0}}, 1'b1};

  // TILE only documents the array edge (indices are scaled outside this
  // block); a non-positive edge is meaningless, so it gets a named branch.
  if (TILE < 1) begin : g_tile_invalid
  end

  state_t           state_r;
  logic             issue_r;
  logic [DIM_W-1:0] m_last_r;
  logic [DIM_W-1:0] n_last_r;
  logic [DIM_W-1:0] k_last_r;
  logic             cfg_zero_s;

  // A job with any zero dimension is rejected rather than run.
  assign cfg_zero_s = (cfg_m_tiles == ZERO) || (cfg_n_tiles == ZERO) ||
                      (cfg_k_tiles == ZERO);

  // Start is qualified by the live ctrl_ready so it lands in the very first
  // ISSUE cycle the controller is idle; issue_r itself is a flop.
  assign ctrl_start = issue_r && ctrl_ready;

  // Job sequencing FSM: state, loop indices, accumulation flags and pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      issue_r   <= 1'b0;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
      job_done  <= 1'b0;
      cfg_err   <= 1'b0;
      m_last_r  <= ZERO;
      n_last_r  <= ZERO;
      k_last_r  <= ZERO;
      tile_m    <= ZERO;
      tile_n    <= ZERO;
      tile_k    <= ZERO;
      acc_clear <= 1'b1;
      acc_last  <= 1'b0;
    end else begin
      job_done <= 1'b0;
      cfg_err  <= 1'b0;
      if (abort && (state_r != IDLE)) begin
        // Cancel: any tile already in the controller runs to completion and
        // its done is ignored once back in IDLE.
        state_r   <= IDLE;
        issue_r   <= 1'b0;
        cfg_ready <= 1'b1;
        busy      <= 1'b0;
        tile_m    <= ZERO;
        tile_n    <= ZERO;
        tile_k    <= ZERO;
        acc_clear <= 1'b1;
        acc_last  <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (cfg_valid) begin
              if (cfg_zero_s) begin
                cfg_err <= 1'b1;
              end else begin
                m_last_r  <= cfg_m_tiles - ONE;
                n_last_r  <= cfg_n_tiles - ONE;
                k_last_r  <= cfg_k_tiles - ONE;
                tile_m    <= ZERO;
                tile_n    <= ZERO;
                tile_k    <= ZERO;
                acc_clear <= 1'b1;
                acc_last  <= (cfg_k_tiles == ONE);
                state_r   <= ISSUE;
                issue_r   <= 1'b1;
                cfg_ready <= 1'b0;
                busy      <= 1'b1;
              end
            end
          end
          ISSUE: begin
            if (ctrl_ready) begin
              state_r <= WAIT;
              issue_r <= 1'b0;
            end
          end
          WAIT: begin
            if (ctrl_done) begin
              state_r <= NEXT;
            end
          end
          NEXT: begin
            if (tile_k != k_last_r) begin
              tile_k    <= tile_k + ONE;
              acc_clear <= 1'b0;
              acc_last  <= ((tile_k + ONE) == k_last_r);
              state_r   <= ISSUE;
              issue_r   <= 1'b1;
            end else if (tile_n != n_last_r) begin
              tile_k    <= ZERO;
              tile_n    <= tile_n + ONE;
              acc_clear <= 1'b1;
              acc_last  <= (k_last_r == ZERO);
              state_r   <= ISSUE;
              issue_r   <= 1'b1;
            end else if (tile_m != m_last_r) begin
              tile_k    <= ZERO;
              tile_n    <= ZERO;
              tile_m    <= tile_m + ONE;
              acc_clear <= 1'b1;
              acc_last  <= (k_last_r == ZERO);
              state_r   <= ISSUE;
              issue_r   <= 1'b1;
            end else begin
              // Last tile finished: indices hold, they never wrap.
              state_r  <= FINISH;
              job_done <= 1'b1;
            end
          end
          FINISH: begin
            state_r   <= IDLE;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
          end
          default: begin
            state_r   <= IDLE;
            issue_r   <= 1'b0;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tile_scheduler.sv
// Self-checking bench for tile_scheduler: a behavioural controller model
// answers each start with a done after a programmable delay, and every start
// is compared against a tile list built by plain nested loops over M, N, K.
module tb_tile_scheduler;
  localparam int DIM_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [DIM_W-1:0] cfg_m_tiles;
  logic [DIM_W-1:0] cfg_n_tiles;
  logic [DIM_W-1:0] cfg_k_tiles;
  logic             abort;
  logic             ctrl_ready;
  logic             ctrl_start;
  logic             ctrl_done;
  logic [DIM_W-1:0] tile_m;
  logic [DIM_W-1:0] tile_n;
  logic [DIM_W-1:0] tile_k;
  logic             acc_clear;
  logic             acc_last;
  logic             busy;
  logic             job_done;
  logic             cfg_err;

  tile_scheduler #(.TILE(8), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_m_tiles(cfg_m_tiles), .cfg_n_tiles(cfg_n_tiles), .cfg_k_tiles(cfg_k_tiles),
    .abort(abort), .ctrl_ready(ctrl_ready), .ctrl_start(ctrl_start), .ctrl_done(ctrl_done),
    .tile_m(tile_m), .tile_n(tile_n), .tile_k(tile_k), .acc_clear(acc_clear),
    .acc_last(acc_last), .busy(busy), .job_done(job_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int m;
    int n;
    int k;
    int kk;
  } tile_t;

  tile_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    done_cnt = 0;
  int    done_delay = 10;
  int    ready_low = 0;
  bit    rand_ready = 1'b0;
  bit    strict = 1'b1;
  bit    first_pending = 1'b0;
  int    n_starts = 0;
  int    n_done = 0;
  int    n_errs = 0;
  int    last_done_cyc = 0;
  int    first_start_cyc = 0;
  int    job_done_cyc = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive controller-side inputs after the edge, sample at negedge.
  task automatic step();
    tile_t t;
    @(posedge clk);
    #1;
    cyc++;
    ctrl_done = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) begin
        ctrl_done = 1'b1;
        last_done_cyc = cyc;
      end
    end
    if (ready_low > 0) begin
      ctrl_ready = 1'b0;
      ready_low--;
    end else begin
      ctrl_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    @(negedge clk);
    if (ctrl_start) begin
      check_eq("start_needs_ready", ctrl_ready, 1);
      check_eq("start_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        t = exp_q.pop_front();
        check_eq("tile_m", tile_m, t.m);
        check_eq("tile_n", tile_n, t.n);
        check_eq("tile_k", tile_k, t.k);
        check_eq("acc_clear", acc_clear, t.k == 0);
        check_eq("acc_last", acc_last, t.k == t.kk - 1);
      end
      if (first_pending) begin
        first_start_cyc = cyc;
        first_pending = 1'b0;
      end else if (strict) begin
        check_eq("done_to_start", cyc - last_done_cyc, 2);
      end
      n_starts++;
      done_cnt = done_delay;
    end
    if (job_done) begin
      n_done++;
      job_done_cyc = cyc;
    end
    if (cfg_err) n_errs++;
  endtask

  task automatic push_job(input int m, input int n, input int k);
    for (int mi = 0; mi < m; mi++)
      for (int ni = 0; ni < n; ni++)
        for (int ki = 0; ki < k; ki++)
          exp_q.push_back('{mi, ni, ki, k});
  endtask

  task automatic run_until_done(input int target);
    int budget;
    budget = 0;
    while (n_done < target && budget < 5000) begin
      step();
      budget++;
    end
    check_eq("job_done_seen", n_done, target);
  endtask

  // Full job from an idle scheduler; hold keeps ctrl_ready low that many cycles.
  task automatic do_job(input int m, input int n, input int k, input int hold);
    int accept_cyc;
    push_job(m, n, k);
    n_starts = 0;
    n_done = 0;
    first_pending = 1'b1;
    cfg_m_tiles = DIM_W'(m);
    cfg_n_tiles = DIM_W'(n);
    cfg_k_tiles = DIM_W'(k);
    cfg_valid = 1'b1;
    ready_low = hold;
    accept_cyc = cyc;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      check_eq("held_no_start", ctrl_start, 0);
      check_eq("held_tile_k", tile_k, 0);
      check_eq("held_tile_n", tile_n, 0);
      check_eq("held_busy", busy, 1);
      step();
    end
    run_until_done(1);
    check_eq("start_count", n_starts, m * n * k);
    if (!rand_ready) check_eq("first_start_lat", first_start_cyc - accept_cyc, 1 + hold);
    check_eq("done_to_job_done", job_done_cyc - last_done_cyc, 2);
    check_eq("queue_drained", exp_q.size(), 0);
    step();
    check_eq("job_done_width", job_done, 0);
    check_eq("busy_after_job", busy, 0);
    check_eq("ready_after_job", cfg_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_cyc;
    int budget;
    int abort_cyc;
    rst = 1'b1;
    cfg_valid = 1'b0;
    abort = 1'b0;
    ctrl_ready = 1'b1;
    ctrl_done = 1'b0;
    cfg_m_tiles = 8'd1;
    cfg_n_tiles = 8'd1;
    cfg_k_tiles = 8'd1;
    repeat (3) @(negedge clk);
    check_eq("rst_cfg_ready", cfg_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ctrl_start", ctrl_start, 0);
    check_eq("rst_job_done", job_done, 0);
    check_eq("rst_cfg_err", cfg_err, 0);
    check_eq("rst_acc_last", acc_last, 0);
    check_eq("rst_acc_clear", acc_clear, 1);
    check_eq("rst_tiles", {tile_m, tile_n, tile_k}, 0);
    rst = 1'b0;
    step();

    // Single-tile job with a slow controller.
    done_delay = 10;
    do_job(1, 1, 1, 0);

    // 2x2x3: twelve starts in K-innermost order.
    done_delay = 3;
    do_job(2, 2, 3, 0);

    // Zero dimension is rejected.
    n_errs = 0;
    n_starts = 0;
    cfg_m_tiles = 8'd2;
    cfg_n_tiles = 8'd0;
    cfg_k_tiles = 8'd3;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    check_eq("cfg_err_pulse", cfg_err, 1);
    check_eq("cfg_err_busy", busy, 0);
    repeat (4) step();
    check_eq("cfg_err_count", n_errs, 1);
    check_eq("cfg_err_no_start", n_starts, 0);
    check_eq("cfg_err_idle", cfg_ready, 1);

    // Controller busy for five ISSUE cycles.
    done_delay = 4;
    do_job(1, 1, 2, 5);

    // Abort while waiting on tile (0,1,1) of a 2x2x2 job.
    done_delay = 10;
    push_job(2, 2, 2);
    n_starts = 0;
    n_done = 0;
    first_pending = 1'b1;
    cfg_m_tiles = 8'd2;
    cfg_n_tiles = 8'd2;
    cfg_k_tiles = 8'd2;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    budget = 0;
    while (n_starts < 4 && budget < 500) begin
      step();
      budget++;
    end
    check_eq("abort_reached_tile", n_starts, 4);
    step();
    step();
    abort = 1'b1;
    abort_cyc = cyc;
    step();
    abort = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_ready", cfg_ready, 1);
    check_eq("abort_tiles", {tile_m, tile_n, tile_k}, 0);
    check_eq("abort_no_job_done", job_done, 0);
    exp_q.delete();
    repeat (12) step();
    check_eq("late_done_arrived", last_done_cyc > abort_cyc, 1);
    check_eq("late_done_ignored_starts", n_starts, 4);
    check_eq("late_done_ignored_done", n_done, 0);
    check_eq("late_done_ignored_busy", busy, 0);
    do_job(1, 1, 1, 0);

    // Abort in the same cycle as ctrl_done: abort wins.
    done_delay = 3;
    push_job(1, 1, 2);
    n_starts = 0;
    n_done = 0;
    first_pending = 1'b1;
    cfg_m_tiles = 8'd1;
    cfg_n_tiles = 8'd1;
    cfg_k_tiles = 8'd2;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    s_cyc = cyc;
    while (ctrl_done !== 1'b1 && cyc < s_cyc + 20) step();
    check_eq("race_done_present", ctrl_done, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("race_busy", busy, 0);
    repeat (6) step();
    check_eq("race_starts", n_starts, 1);
    check_eq("race_no_job_done", n_done, 0);
    exp_q.delete();

    // cfg_valid held across a job: one re-accept, one cycle after job_done.
    done_delay = 2;
    push_job(1, 2, 1);
    push_job(1, 2, 1);
    n_starts = 0;
    n_done = 0;
    first_pending = 1'b1;
    cfg_m_tiles = 8'd1;
    cfg_n_tiles = 8'd2;
    cfg_k_tiles = 8'd1;
    cfg_valid = 1'b1;
    step();
    run_until_done(1);
    check_eq("held_valid_starts", n_starts, 2);
    step();
    check_eq("b2b_gap_ready", cfg_ready, 1);
    check_eq("b2b_gap_busy", busy, 0);
    first_pending = 1'b1;
    step();
    check_eq("b2b_reaccept_busy", busy, 1);
    cfg_valid = 1'b0;
    run_until_done(2);
    check_eq("b2b_total_starts", n_starts, 4);
    check_eq("b2b_queue", exp_q.size(), 0);
    step();

    // Randomized jobs, half with a jittery ctrl_ready.
    for (int j = 0; j < 8; j++) begin
      rand_ready = j[0];
      strict = !rand_ready;
      done_delay = $urandom_range(1, 6);
      do_job($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tile_scheduler.md
# tile_scheduler

Sequences the 8x8 systolic-array matrix-multiply controller over a tiled job so that matrices larger than one array tile can be multiplied. Accepts a job size in tiles (M x N x K), issues one controller start per tile product, waits for each done, and drives the tile indices and accumulation flags consumed by the A/B/C buffer address logic. Sits between the host-facing job interface and the single-tile controller.

## Interface

- TILE, default 8: array edge; informational, with tile indices scaled externally.
- DIM_W, default 8: width of tile-count fields and tile indices.

- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- cfg_valid  in  1  job request
- cfg_ready  out  1  job accepted when high with cfg_valid
- cfg_m_tiles / cfg_n_tiles / cfg_k_tiles  in  DIM_W each  job size in tiles, 1..2^DIM_W-1
- abort  in  1  synchronous job cancel
- ctrl_ready  in  1  tile controller idle
- ctrl_start  out  1  one-cycle start to tile controller
- ctrl_done  in  1  one-cycle tile-complete from tile controller
- tile_m / tile_n / tile_k  out  DIM_W each  current tile indices
- acc_clear  out  1  current tile is the first K tile (k == 0)
- acc_last  out  1  current tile is the last K tile (k == K-1); C tile final
- busy  out  1  job in progress
- job_done  out  1  one-cycle job-complete pulse
- cfg_err  out  1  one-cycle pulse: job rejected (a zero dimension)

## Operation

- States: IDLE, ISSUE, WAIT, NEXT, FINISH.
- IDLE: cfg_ready=1. On cfg_valid, register all three sizes, clear m/n/k to 0, go to ISSUE. If any size is 0: pulse cfg_err, stay in IDLE, register nothing.
- ISSUE: ctrl_start=1 only when ctrl_ready=1, then go to WAIT; otherwise hold ISSUE with ctrl_start=0.
- WAIT: on ctrl_done, go to NEXT. ctrl_done is ignored in every other state.
- NEXT: advance the loop. K is innermost, then N, then M: k+1; on k==K-1, k=0 and n+1; on n==N-1, n=0 and m+1. If the tile just finished was (M-1, N-1, K-1), go to FINISH; otherwise go to ISSUE.
- FINISH: job_done=1 for one cycle, then go to IDLE.
- Indices and flags are registered. They stay stable from ISSUE through WAIT and update only on the NEXT transition.
- acc_clear and acc_last are decoded from registered k and K. With K=1, both are high.
- Counters compare against registered size-1 and never wrap. Maximum job is (2^DIM_W-1)^3 tiles.
- abort, in any non-IDLE state: go to IDLE next cycle with no job_done. Indices reset to 0.
  - An in-flight tile in the controller is not cancelled.
  - A ctrl_done arriving afterward in IDLE is ignored.
  - abort in IDLE has no effect.
- busy = (state != IDLE).
- cfg_valid is ignored while busy.

## Timing

- Reset values:
  - State IDLE, cfg_ready=1.
  - ctrl_start, busy, job_done, cfg_err, acc_last all 0.
  - tile_m/n/k = 0; acc_clear = 1, since it is decoded from k==0.
- Job accept to first ctrl_start: 1 cycle, when ctrl_ready=1.
- ctrl_done to next ctrl_start: 2 cycles (NEXT, then ISSUE).
- Last ctrl_done to job_done: 2 cycles.
- job_done to cfg_ready: 1 cycle, so back-to-back jobs are separated by 1 idle cycle.
- Simultaneous abort and ctrl_done in WAIT: abort wins.
- cfg_err is asserted in the cycle after the rejected cfg_valid.

## Test plan

- 1x1x1 job, controller model with done 10 cycles after start: exactly 1 ctrl_start with acc_clear=1 and acc_last=1; job_done 2 cycles after ctrl_done; busy then falls.
- 2x2x3 job: 12 starts with (m,n,k) sequence (0,0,0),(0,0,1),(0,0,2),(0,1,0)...(1,1,2); acc_last only when k=2; acc_clear only when k=0.
- cfg with n_tiles=0: cfg_err pulses once, busy stays 0, no ctrl_start.
- ctrl_ready held low 5 cycles in ISSUE: ctrl_start is delayed and issued exactly once when ctrl_ready rises; indices unchanged throughout.
- abort during WAIT of tile (0,1,1) in a 2x2x2 job: IDLE next cycle, no job_done; a later ctrl_done is ignored; a new 1x1x1 job runs normally.
- cfg_valid asserted throughout a running job: no re-accept. A second job is accepted exactly 1 cycle after job_done.
